// File: rtl/fir_pkg.sv
// Shared definitions for the FIR engines: default sizing, scheduler states,
// and the accumulator-to-sample saturation helper.
package fir_pkg;

  // Default geometry; the folded scheduler takes its parameter defaults from here.
  localparam int DEF_BITWIDTH = 16;
  localparam int DEF_ACCWIDTH = 24;
  localparam int DEF_N        = 16;
  localparam int DEF_P        = 4;
  localparam int PASSES       = DEF_N / DEF_P;
  localparam int PTR_W        = $clog2(DEF_N);

  // Working width of the saturation helper; wide enough for any sane ACCWIDTH.
  localparam int SAT_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Clamp a sign-extended accumulator to the signed range of out_w bits.
  // The caller keeps the low out_w bits of the result.
  function automatic logic signed [SAT_W-1:0] saturate(
    input logic signed [SAT_W-1:0] acc,
    input int                      out_w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) << (out_w - 1)) - SAT_W'(1);
    lo = ~hi;
    if (acc > hi) begin
      return hi;
    end else if (acc < lo) begin
      return lo;
    end else begin
      return acc;
    end
  endfunction

endpackage

// File: rtl/fir_mac_lane.sv
// One multiply lane: signed coefficient x signed sample, result kept as the
// low ACCWIDTH bits of the full 2*BITWIDTH product (sign-extended if wider).
module fir_mac_lane #(
  parameter int BITWIDTH = 16,
  parameter int ACCWIDTH = 24
) (
  input  logic signed [BITWIDTH-1:0] coef_i,
  input  logic signed [BITWIDTH-1:0] sample_i,
  output logic signed [ACCWIDTH-1:0] prod_o
);

  // Multiplying the operands sign-extended to ACCWIDTH gives exactly the low
  // ACCWIDTH bits of the full-precision product (arithmetic mod 2^ACCWIDTH),
  // and the exact product when ACCWIDTH >= 2*BITWIDTH.
  assign prod_o = ACCWIDTH'(coef_i) * ACCWIDTH'(sample_i);

endmodule

// File: rtl/fir_fold_sched.sv
// Folded FIR scheduler: P shared MAC lanes walk the N taps in N/P passes per
// accepted sample, then hold the saturated result until the consumer takes it.
module fir_fold_sched
  import fir_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH,
  parameter int ACCWIDTH = DEF_ACCWIDTH,
  parameter int N        = DEF_N,
  parameter int P        = DEF_P
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BITWIDTH-1:0]  in_data,
  input  logic                 coef_wr,
  input  logic [$clog2(N)-1:0] coef_addr,
  input  logic [BITWIDTH-1:0]  coef_data,
  output logic                 coef_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BITWIDTH-1:0]  out_data
);

  localparam int PASSES_L = N / P;
  localparam int PTR_W_L  = $clog2(N);

  state_e                      state_q;
  logic [PTR_W_L-1:0]          wp_q;
  logic [PTR_W_L-1:0]          wp_nxt;
  logic [PTR_W_L-1:0]          j_q;
  logic signed [BITWIDTH-1:0]  coef_q  [N];
  logic signed [BITWIDTH-1:0]  dline_q [N];
  logic signed [ACCWIDTH-1:0]  acc_q;
  logic signed [ACCWIDTH-1:0]  acc_d;
  logic signed [ACCWIDTH-1:0]  tree_sum;
  logic signed [SAT_W-1:0]     acc_ext;
  logic signed [BITWIDTH-1:0]  lane_coef [P];
  logic signed [BITWIDTH-1:0]  lane_samp [P];
  logic signed [ACCWIDTH-1:0]  lane_prod [P];
  logic                        accept;
  logic                        coef_we;
  logic                        last_pass;
  logic                        out_valid_q;
  logic                        coef_err_q;
  logic signed [BITWIDTH-1:0]  out_data_q;

  // Ready depends on state only, so there is no path from in_valid to in_ready.
  assign in_ready  = (state_q == IDLE);
  assign accept    = in_ready & in_valid;
  assign coef_we   = in_ready & coef_wr;
  assign wp_nxt    = (wp_q == PTR_W_L'(N - 1)) ? '0 : wp_q + 1'b1;
  assign last_pass = (j_q == PTR_W_L'(PASSES_L - 1));

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign coef_err  = coef_err_q;

  // Select each lane's tap k = j*P + l and the sample x[n-k] at (wp - k) mod N.
  always_comb begin
    int k;
    int idx;
    // NOTE: every combinational output gets a value on every path (defaults
    // first, or a fully covering loop) so no latch is inferred.
    k   = 0;
    idx = 0;
    for (int l = 0; l < P; l++) begin
      k   = int'(j_q) * P + l;
      idx = (int'(wp_q) >= k) ? int'(wp_q) - k : int'(wp_q) + N - k;
      lane_coef[l] = coef_q[PTR_W_L'(k)];
      lane_samp[l] = dline_q[PTR_W_L'(idx)];
    end
  end

  for (genvar l = 0; l < P; l++) begin : g_lane
    fir_mac_lane #(
      .BITWIDTH (BITWIDTH),
      .ACCWIDTH (ACCWIDTH)
    ) u_lane (
      .coef_i   (lane_coef[l]),
      .sample_i (lane_samp[l]),
      .prod_o   (lane_prod[l])
    );
  end

  // Adder tree over the lane products; everything wraps mod 2^ACCWIDTH.
  always_comb begin
    // NOTE: blocking assignments here build the running sum within one
    // evaluation; registered state below uses non-blocking only.
    tree_sum = '0;
    for (int l = 0; l < P; l++) begin
      tree_sum = tree_sum + lane_prod[l];
    end
    acc_d   = acc_q + tree_sum;
    acc_ext = SAT_W'(acc_d);
  end

  // Coefficient bank and delay line: written only from IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these arrays are reset on purpose: a reset must leave zeroed
      // coefficients and an all-zero history, which costs flops, not RAM.
      for (int k = 0; k < N; k++) begin
        coef_q[k]  <= '0;
        dline_q[k] <= '0;
      end
    end else begin
      if (coef_we) begin
        coef_q[coef_addr] <= coef_data;
      end
      if (accept) begin
        dline_q[wp_nxt] <= in_data;
      end
    end
  end

  // Scheduler FSM with registered outputs, pass counter and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wp_q        <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      coef_err_q  <= 1'b0;
    end else begin
      // A write outside IDLE is dropped and flagged for exactly one cycle.
      coef_err_q <= coef_wr & ~in_ready;
      case (state_q)
        IDLE: begin
          if (accept) begin
            wp_q    <= wp_nxt;
            j_q     <= '0;
            acc_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          j_q   <= j_q + 1'b1;
          if (last_pass) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            out_data_q  <= BITWIDTH'(saturate(acc_ext, BITWIDTH));
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_fold_sched.sv
// Directed bench for the folded FIR scheduler (N=16, P=4, 16/24-bit).
module tb_fir_fold_sched;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        coef_wr;
  logic [3:0]  coef_addr;
  logic [15:0] coef_data;
  logic        coef_err;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int x;
    int y;
  } vec_t;

  vec_t imp_v  [17];
  vec_t ramp_v [8];
  vec_t sat_v  [3];
  int   ramp_y [8] = '{0, 1, 4, 10, 20, 35, 56, 84};

  fir_fold_sched #(
    .BITWIDTH (16),
    .ACCWIDTH (24),
    .N        (16),
    .P        (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .coef_wr   (coef_wr),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .coef_err  (coef_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; waits (bounded) until the DUT can take a sample.
  task automatic wait_ready(input string tag);
    int w;
    w = 0;
    while (in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_ready"}, int'(in_ready), 1);
  endtask

  // Called at a negedge; waits (bounded) for out_valid.
  task automatic wait_valid(input string tag);
    int w;
    w = 0;
    while (out_valid !== 1'b1 && w < 30) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_valid"}, int'(out_valid), 1);
  endtask

  // Presents one sample; returns at the negedge right after the accepting edge.
  task automatic accept(input string tag, input int x);
    wait_ready(tag);
    in_valid = 1'b1;
    in_data  = 16'(x);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // From the negedge after the accept edge: cycles until out_valid (lat) and
  // until in_ready returns (gap), scrambling the inputs meanwhile.
  task automatic measure(output int y, output int lat, output int gap);
    lat = -1;
    gap = -1;
    y   = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid === 1'b1 && lat < 0) begin
        lat = i;
        y   = int'($signed(out_data));
      end
      if (in_ready === 1'b1 && gap < 0) gap = i;
      if (lat >= 0 && gap >= 0) break;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 16'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_check(input string tag, input int x, input int exp_y);
    int y;
    int lat;
    int gap;
    accept(tag, x);
    measure(y, lat, gap);
    check({tag, "_y"}, y, exp_y);
    check({tag, "_lat"}, lat, 4);
    check({tag, "_gap"}, gap, 5);
  endtask

  task automatic write_coef(input int addr, input int data);
    coef_wr   = 1'b1;
    coef_addr = 4'(addr);
    coef_data = 16'(data);
    @(posedge clk);
    @(negedge clk);
    coef_wr   = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int seen;

    // Vector tables.
    for (int k = 0; k < 17; k++) begin
      imp_v[k].x = (k == 0) ? 1 : 0;
      imp_v[k].y = (k < 16) ? k : 0;
    end
    for (int k = 0; k < 8; k++) begin
      ramp_v[k].x = k + 1;
      ramp_v[k].y = ramp_y[k];
    end
    sat_v[0] = '{x: 400,  y: 32767};
    sat_v[1] = '{x: -400, y: -32768};
    sat_v[2] = '{x: 300,  y: 30000};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    coef_wr   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    check("rst_in_ready",  int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data",  int'(out_data), 0);
    check("rst_coef_err",  int'(coef_err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Impulse response with c[k] = k.
    for (int k = 0; k < 16; k++) write_coef(k, k);
    for (int i = 0; i < 17; i++) begin
      send_check($sformatf("imp%0d", i), imp_v[i].x, imp_v[i].y);
    end

    // Ramp; history is all zero after the impulse run.
    for (int i = 0; i < 8; i++) begin
      send_check($sformatf("ramp%0d", i), ramp_v[i].x, ramp_v[i].y);
    end

    // Saturation with c[0] = 100 only.
    pulse_reset();
    write_coef(0, 100);
    for (int i = 0; i < 3; i++) begin
      send_check($sformatf("sat%0d", i), sat_v[i].x, sat_v[i].y);
    end

    // Backpressure: c[1] = 1 so the previous sample shows up in the result.
    write_coef(1, 1);
    out_ready = 1'b0;
    accept("bp", 5);
    wait_valid("bp");
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp%0d_valid", c), int'(out_valid), 1);
      check($sformatf("bp%0d_data", c), int'($signed(out_data)), 800);
      check($sformatf("bp%0d_in_ready", c), int'(in_ready), 0);
      in_valid = 1'b1;
      in_data  = 16'(99);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready",  int'(in_ready), 1);
    check("bp_release_out_valid", int'(out_valid), 0);
    // 100*2 + 1*5: the held 99 must never have entered the delay line.
    send_check("bp_next", 2, 205);

    // Coefficient write during RUN is dropped and flagged once.
    accept("crun", 3);
    coef_wr   = 1'b1;
    coef_addr = 4'd0;
    coef_data = 16'd7;
    @(posedge clk);
    @(negedge clk);
    coef_wr = 1'b0;
    check("crun_err_pulse", int'(coef_err), 1);
    @(negedge clk);
    check("crun_err_clear", int'(coef_err), 0);
    wait_valid("crun");
    check("crun_y", int'($signed(out_data)), 302);

    // Same write together with a sample accept in IDLE: applies to that sample.
    wait_ready("cidle");
    in_valid  = 1'b1;
    in_data   = 16'd4;
    coef_wr   = 1'b1;
    coef_addr = 4'd0;
    coef_data = 16'd7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    coef_wr  = 1'b0;
    check("cidle_no_err", int'(coef_err), 0);
    wait_valid("cidle");
    check("cidle_y", int'($signed(out_data)), 31);

    // Reset during pass 2 aborts the computation and clears the state.
    accept("rrun", 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rrun_out_valid", int'(out_valid), 0);
    check("rrun_in_ready",  int'(in_ready), 1);
    check("rrun_coef_err",  int'(coef_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid !== 1'b0) seen = 1;
      @(negedge clk);
    end
    check("rrun_no_output", seen, 0);
    send_check("rrun_impulse", 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_fold_sched.md
# fir_fold_sched

Time-multiplexed FIR engine: a scheduler that shares P multiply-accumulate lanes across N taps, folding one output computation into N/P passes. It sits between the sample source and the downstream consumer. Handshakes are valid/ready on both sides, and a simple write port loads the coefficient bank. With defaults (N=16, P=4) it gives one filtered sample every 6 cycles from 4 multipliers instead of 16.

## Interface
- BITWIDTH, 16, sample/coefficient/output width (signed two's complement)
- ACCWIDTH, 24, accumulator width; must be ≥ BITWIDTH
- N, 16, number of taps; must be a multiple of P
- P, 4, number of MAC lanes; PASSES = N/P
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input sample valid
- in_ready  out  1  scheduler can accept a sample
- in_data  in  BITWIDTH  input sample x[n]
- coef_wr  in  1  coefficient write strobe
- coef_addr  in  $clog2(N)  tap index k
- coef_data  in  BITWIDTH  coefficient c[k]
- coef_err  out  1  one-cycle pulse when a write is dropped
- out_valid  out  1  output sample valid
- out_ready  in  1  consumer accepts output
- out_data  out  BITWIDTH  y[n], saturated

## Operation
- The block has one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset state:
  - FSM state is IDLE.
  - in_ready=1, out_valid=0, out_data=0, coef_err=0.
  - All N coefficients are 0, all N delay-line entries are 0, and the write pointer wp is 0.
- FSM states are IDLE, RUN, and HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready the block writes in_data to buf[wp'], where wp'=wp+1 mod N. It sets wp=wp', clears the accumulator and the pass counter j=0, and goes to RUN.
- RUN:
  - in_ready=0.
  - On each cycle, lane l (0..P-1) uses tap k=j*P+l and adds c[k]*buf[(wp−k) mod N] into the accumulator; j increments.
  - After pass j=PASSES−1 the FSM goes to HOLD and registers out_data and out_valid=1 on the same edge.
- HOLD:
  - out_valid=1 and out_data is held stable.
  - On out_ready the block clears out_valid and returns to IDLE.
  - With out_ready low, the FSM stays in HOLD indefinitely.
- Result: y[n] = Σ_{k=0}^{N−1} c[k]·x[n−k]. Samples before the first accepted one count as 0.
- Arithmetic:
  - Each product is computed at full 2·BITWIDTH, then sign-truncated to its low ACCWIDTH bits.
  - The sum wraps modulo 2^ACCWIDTH.
  - out_data is the accumulator saturated to [−2^(BITWIDTH−1), 2^(BITWIDTH−1)−1].
- Coefficient writes:
  - A write takes effect at the clock edge in IDLE only.
  - A coef_wr in RUN or HOLD is dropped and coef_err pulses high for the following cycle.
  - A coefficient write and a sample accept on the same IDLE edge are both performed. The new coefficient is used for that sample.
- Reset asserted mid-RUN or mid-HOLD aborts the computation immediately. No output is produced, and the delay line and coefficients are cleared.

## Timing
- The sample is accepted at edge E. RUN covers edges E+1..E+PASSES, and out_valid rises after edge E+PASSES. Latency is PASSES cycles (4 with defaults).
- With out_ready tied high, HOLD lasts 1 cycle. The next in_ready is high after edge E+PASSES+1, giving a throughput of 1 sample per PASSES+2 cycles (6).
- in_ready is a pure function of state, with no combinational path from in_valid. out_valid and out_data are registered.
- Input hold rule: in_data and in_valid may change freely while in_ready=0; only the accepting edge matters.
- Delay-line wrap: wp rolls N−1→0, and tap addressing is modulo N.

## Structure
- Shared package fir_pkg holds:
  - localparams PASSES and PTR_W=$clog2(N);
  - the state enum typedef (IDLE/RUN/HOLD);
  - the saturate function (ACCWIDTH→BITWIDTH), reusable by the parallel fir.
- Sub-module fir_mac_lane (P instances) takes a coefficient and a sample and returns the product truncated to ACCWIDTH. The scheduler owns the adder tree, the accumulator, the FSM, wp, j, the delay line and the coefficient bank.

## Test plan
- **Impulse:** load c[k]=k for k=0..15, then send 1 followed by 16 zeros → outputs 0,1,2,…,15, then 0. Check out_valid rises exactly 4 cycles after each accept.
- **Ramp:** with c[k]=k, send 1,2,3,… → outputs 0,1,4,10,20,… (y[n]=Σ k·(n+1−k)). Check in_ready is low for exactly 5 cycles between accepts with out_ready=1.
- **Saturation:**
  - c[0]=100, others 0. Input 400 → out_data=32767; input −400 → −32768; input 300 → 30000.
- **Backpressure:** hold out_ready=0 for 10 cycles → out_valid and out_data are stable, in_ready stays 0, and no sample is accepted. Releasing out_ready gives in_ready=1 on the next cycle.
- **Coefficient during RUN:** pulse coef_wr (addr 0, data 7) in RUN → coef_err pulses once and the output is unchanged. The same write in IDLE applies to the next sample.
- **Reset mid-RUN:** drop rst_n during pass 2 → out_valid=0, in_ready=1, and the next impulse with zeroed coefficients gives an output of 0.
